// File: rtl/cart_rom_arb.sv
// Purpose : shares one cartridge ROM port between the mapper's PRG and CHR read channels.
// Latency : grant one edge after a request is seen pending; channel ack one edge after memack (2 cycles minimum).
// Backpres: requests are levels held until ack; memreq is held until memack, and one req level yields one read.
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   promaddr/promreq/promack   PRG read channel; promdata is held until the next promack
//   cromaddr/cromreq/cromack   CHR read channel; cromdata is held until the next cromack
//   memaddr/memreq/memack      memory port; memaddr[21] selects CHR (1) or PRG (0)
//   memrdata                   read data, valid only in the memack cycle
module cart_rom_arb #(
    parameter int MAXCHR = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] promaddr,
    input  logic        promreq,
    output logic        promack,
    output logic [7:0]  promdata,
    input  logic [20:0] cromaddr,
    input  logic        cromreq,
    output logic        cromack,
    output logic [7:0]  cromdata,
    output logic [21:0] memaddr,
    output logic        memreq,
    input  logic        memack,
    input  logic [7:0]  memrdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSYP = 2'd1,
        BUSYC = 2'd2
    } state_t;

    state_t     state;
    logic       pdone;
    logic       cdone;
    logic [1:0] chrcnt;
    logic       ppend;
    logic       cpend;

    // A channel that has already been acked for its current req level is not
    // pending again until the mapper lowers req for at least one edge.
    assign ppend = promreq && !pdone;
    assign cpend = cromreq && !cdone;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pdone    <= 1'b0;
            cdone    <= 1'b0;
            chrcnt   <= 2'd0;
            memreq   <= 1'b0;
            memaddr  <= 22'd0;
            promack  <= 1'b0;
            cromack  <= 1'b0;
            promdata <= 8'd0;
            cromdata <= 8'd0;
        end else begin
            promack <= 1'b0;
            cromack <= 1'b0;
            if (!promreq) pdone <= 1'b0;
            if (!cromreq) cdone <= 1'b0;

            case (state)
                IDLE: begin
                    // CHR wins unless it has already taken MAXCHR grants in a
                    // row while PRG was waiting.
                    if (cpend && (!ppend || chrcnt < 2'(MAXCHR))) begin
                        state   <= BUSYC;
                        memreq  <= 1'b1;
                        memaddr <= {1'b1, cromaddr};
                        chrcnt  <= ppend ? chrcnt + 2'd1 : 2'd0;
                    end else if (ppend) begin
                        state   <= BUSYP;
                        memreq  <= 1'b1;
                        memaddr <= {1'b0, promaddr};
                        chrcnt  <= 2'd0;
                    end
                end
                BUSYP: begin
                    if (memack) begin
                        state    <= IDLE;
                        memreq   <= 1'b0;
                        promack  <= 1'b1;
                        promdata <= memrdata;
                        // A req dropped mid-read has nothing left to block.
                        if (promreq) pdone <= 1'b1;
                    end
                end
                BUSYC: begin
                    if (memack) begin
                        state    <= IDLE;
                        memreq   <= 1'b0;
                        cromack  <= 1'b1;
                        cromdata <= memrdata;
                        if (cromreq) cdone <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memreq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_rom_arb.sv
module tb_cart_rom_arb;

    logic        clk;
    logic        reset;
    logic [20:0] promaddr;
    logic        promreq;
    logic        promack;
    logic [7:0]  promdata;
    logic [20:0] cromaddr;
    logic        cromreq;
    logic        cromack;
    logic [7:0]  cromdata;
    logic [21:0] memaddr;
    logic        memreq;
    logic        memack;
    logic [7:0]  memrdata;

    int checks = 0;
    int errors = 0;

    cart_rom_arb #(.MAXCHR(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .promaddr (promaddr),
        .promreq  (promreq),
        .promack  (promack),
        .promdata (promdata),
        .cromaddr (cromaddr),
        .cromreq  (cromreq),
        .cromack  (cromack),
        .cromdata (cromdata),
        .memaddr  (memaddr),
        .memreq   (memreq),
        .memack   (memack),
        .memrdata (memrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        preq;
        logic [20:0] paddr;
        logic        creq;
        logic [20:0] caddr;
        logic        mack;
        logic [7:0]  mdata;
        logic        mr;
        logic [21:0] ma;
        logic        pack;
        logic [7:0]  pd;
        logic        cack;
        logic [7:0]  cd;
    } vec_t;

    function automatic vec_t mk(input logic preq, input logic [20:0] paddr,
                                input logic creq, input logic [20:0] caddr,
                                input logic mack, input logic [7:0] mdata,
                                input logic mr, input logic [21:0] ma,
                                input logic pack, input logic [7:0] pd,
                                input logic cack, input logic [7:0] cd);
        vec_t v;
        v.preq = preq; v.paddr = paddr; v.creq = creq; v.caddr = caddr;
        v.mack = mack; v.mdata = mdata; v.mr = mr; v.ma = ma;
        v.pack = pack; v.pd = pd; v.cack = cack; v.cd = cd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " memreq"},   32'(memreq),   32'(v.mr));
        check({tag, " memaddr"},  32'(memaddr),  32'(v.ma));
        check({tag, " promack"},  32'(promack),  32'(v.pack));
        check({tag, " promdata"}, 32'(promdata), 32'(v.pd));
        check({tag, " cromack"},  32'(cromack),  32'(v.cack));
        check({tag, " cromdata"}, 32'(cromdata), 32'(v.cd));
    endtask

    // Drive inputs just after an edge, let one rising edge happen, then
    // compare the registered outputs 1 ns later.
    task automatic step(input string tag, input vec_t v);
        promreq  = v.preq;
        promaddr = v.paddr;
        cromreq  = v.creq;
        cromaddr = v.caddr;
        memack   = v.mack;
        memrdata = v.mdata;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    task automatic idle_inputs();
        promreq = 1'b0; promaddr = '0; cromreq = 1'b0; cromaddr = '0;
        memack = 1'b0; memrdata = '0;
    endtask

    vec_t tbl[16];
    vec_t seq[8];
    vec_t zero_v;

    initial begin
        //                 preq paddr     creq caddr     mack data   mr ma          pack pd     cack cd
        tbl[0]  = mk(1, 21'h04123, 0, 21'h0,     0, 8'h00, 1, 22'h004123, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(1, 21'h04123, 0, 21'h0,     0, 8'h00, 1, 22'h004123, 0, 8'h00, 0, 8'h00);
        tbl[2]  = mk(1, 21'h04999, 0, 21'h0,     0, 8'h00, 1, 22'h004123, 0, 8'h00, 0, 8'h00);
        tbl[3]  = mk(1, 21'h04123, 0, 21'h0,     1, 8'hA5, 0, 22'h004123, 1, 8'hA5, 0, 8'h00);
        tbl[4]  = mk(1, 21'h04123, 0, 21'h0,     0, 8'h00, 0, 22'h004123, 0, 8'hA5, 0, 8'h00);
        tbl[5]  = mk(1, 21'h04123, 0, 21'h0,     0, 8'h00, 0, 22'h004123, 0, 8'hA5, 0, 8'h00);
        tbl[6]  = mk(0, 21'h0,     0, 21'h0,     0, 8'h00, 0, 22'h004123, 0, 8'hA5, 0, 8'h00);
        tbl[7]  = mk(0, 21'h0,     1, 21'h01FFF, 0, 8'h00, 1, 22'h201FFF, 0, 8'hA5, 0, 8'h00);
        tbl[8]  = mk(0, 21'h0,     1, 21'h01FFF, 1, 8'h3C, 0, 22'h201FFF, 0, 8'hA5, 1, 8'h3C);
        tbl[9]  = mk(0, 21'h0,     0, 21'h0,     0, 8'h00, 0, 22'h201FFF, 0, 8'hA5, 0, 8'h3C);
        tbl[10] = mk(0, 21'h0,     0, 21'h0,     1, 8'hFF, 0, 22'h201FFF, 0, 8'hA5, 0, 8'h3C);
        tbl[11] = mk(1, 21'h00010, 0, 21'h0,     0, 8'h00, 1, 22'h000010, 0, 8'hA5, 0, 8'h3C);
        tbl[12] = mk(1, 21'h00010, 1, 21'h00020, 1, 8'h11, 0, 22'h000010, 1, 8'h11, 0, 8'h3C);
        tbl[13] = mk(1, 21'h00010, 1, 21'h00020, 0, 8'h00, 1, 22'h200020, 0, 8'h11, 0, 8'h3C);
        tbl[14] = mk(0, 21'h0,     1, 21'h00020, 1, 8'h22, 0, 22'h200020, 0, 8'h11, 1, 8'h22);
        tbl[15] = mk(0, 21'h0,     0, 21'h0,     0, 8'h00, 0, 22'h200020, 0, 8'h11, 0, 8'h22);

        zero_v = mk(0, 21'h0, 0, 21'h0, 0, 8'h00, 0, 22'h0, 0, 8'h00, 0, 8'h00);

        // Reset state
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", zero_v);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single PRG, single CHR, spurious memack, zero-wait back-to-back
        for (int i = 0; i < 16; i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        // Contention, MAXCHR=2: both reqs rise together from reset. cromreq
        // is low across each CHR ack edge so its done flag stays clear and
        // CHR is pending again at the next decision; expected order is
        // CHR, CHR, PRG, CHR with memreq low one cycle between grants.
        reset = 1'b0;
        idle_inputs();
        #2;
        reset = 1'b1;
        seq[0] = mk(1, 21'h00AAA, 1, 21'h00111, 0, 8'h00, 1, 22'h200111, 0, 8'h00, 0, 8'h00);
        seq[1] = mk(1, 21'h00AAA, 0, 21'h0,     1, 8'h01, 0, 22'h200111, 0, 8'h00, 1, 8'h01);
        seq[2] = mk(1, 21'h00AAA, 1, 21'h00222, 0, 8'h00, 1, 22'h200222, 0, 8'h00, 0, 8'h01);
        seq[3] = mk(1, 21'h00AAA, 0, 21'h0,     1, 8'h02, 0, 22'h200222, 0, 8'h00, 1, 8'h02);
        seq[4] = mk(1, 21'h00AAA, 1, 21'h00333, 0, 8'h00, 1, 22'h000AAA, 0, 8'h00, 0, 8'h02);
        seq[5] = mk(1, 21'h00AAA, 1, 21'h00333, 1, 8'h03, 0, 22'h000AAA, 1, 8'h03, 0, 8'h02);
        seq[6] = mk(1, 21'h00AAA, 1, 21'h00333, 0, 8'h00, 1, 22'h200333, 0, 8'h03, 0, 8'h02);
        seq[7] = mk(0, 21'h0,     1, 21'h00333, 1, 8'h04, 0, 22'h200333, 0, 8'h03, 1, 8'h04);
        for (int i = 0; i < 8; i++)
            step($sformatf("arb%0d", i), seq[i]);
        step("arb_end", mk(0, 21'h0, 0, 21'h0, 0, 8'h00, 0, 22'h200333, 0, 8'h03, 0, 8'h04));

        // Reset mid-transaction: abort takes effect without a clock edge
        step("rst_grant", mk(1, 21'h1ABCD, 0, 21'h0, 0, 8'h00, 1, 22'h1ABCD, 0, 8'h03, 0, 8'h04));
        #2;
        reset = 1'b0;
        #1;
        check_outs("rst_async", zero_v);
        promreq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("rst_late_ack", mk(0, 21'h0, 0, 21'h0, 1, 8'h77, 0, 22'h0, 0, 8'h00, 0, 8'h00));
        step("rst_after",    zero_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
